// File: rtl/game_state_controller_pkg.sv
// Shared game types and default parameter values for the game sequencer.
package game_defines;
  typedef enum logic [2:0] {
    IDLE, SERVE, PLAY, PAUSED, BALL_LOST, LEVEL_UP, GAME_OVER, WIN
  } game_state_t;

  localparam logic [15:0] MAX_SCORE = 16'hFFFF;

  localparam int INITIAL_LIVES_D  = 3;
  localparam int NUM_LEVELS_D     = 4;
  localparam int BOTTOM_Y_D       = 479;
  localparam int HOLD_FRAMES_D    = 60;
  localparam int POINTS_PER_HIT_D = 10;

  // Widened add so a carry out of 16 bits clamps instead of wrapping.
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [16:0] b);
    logic [17:0] s;
    s = {2'b00, a} + {1'b0, b};
    return (s > {2'b00, MAX_SCORE}) ? MAX_SCORE : s[15:0];
  endfunction
endpackage

// File: rtl/game_state_controller_rise_edge_detector.sv
// One-cycle pulse on a rising edge of a level input, against a registered history.
module rise_edge_detector (
  input  logic clk,
  input  logic resetN,
  input  logic in,
  output logic pulse
);
  logic hist;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) hist <= 1'b0;
    else         hist <= in;
  end

  assign pulse = in & ~hist;
endmodule

// File: rtl/game_state_controller.sv
// Game sequencer: serve/play/pause/level-up/end-of-game FSM, lives and saturating score.
// Build option: define AUTO_SERVE_EN to re-serve automatically after a lost ball.
module game_state_controller
  import game_defines::*;
#(
  parameter int INITIAL_LIVES  = INITIAL_LIVES_D,
  parameter int NUM_LEVELS     = NUM_LEVELS_D,
  parameter int BOTTOM_Y       = BOTTOM_Y_D,
  parameter int HOLD_FRAMES    = HOLD_FRAMES_D,
  parameter int POINTS_PER_HIT = POINTS_PER_HIT_D
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyStartIsPressed,
  input  logic               keyPauseIsPressed,
  input  logic signed [10:0] smileyTopLeftY,
  input  logic               collisionSmileyObstacle,
  input  logic               levelCleared,
  output logic               pause,
  output logic               reset_level,
  output logic [3:0]         level,
  output logic [1:0]         lives,
  output logic [15:0]        score,
  output logic               gameOver,
  output logic               win
);
  localparam int CW = $clog2(HOLD_FRAMES + 1);
  localparam logic signed [10:0] BOTTOM_S   = BOTTOM_Y[10:0];
  localparam logic [3:0]         LAST_LEVEL = 4'(NUM_LEVELS - 1);
  localparam logic [1:0]         INIT_LIVES = 2'(INITIAL_LIVES);

  // bit 0 start, bit 1 pause, bit 2 collision
  logic [2:0] key_lvl, key_rise;
  assign key_lvl = {collisionSmileyObstacle, keyPauseIsPressed, keyStartIsPressed};

  rise_edge_detector u_red [2:0] (
    .clk    (clk),
    .resetN (resetN),
    .in     (key_lvl),
    .pulse  (key_rise)
  );

  logic start_p, pause_p, hit_p;
  assign start_p = key_rise[0];
  assign pause_p = key_rise[1];
  assign hit_p   = key_rise[2];

  game_state_t   state, state_n;
  logic [3:0]    level_n;
  logic [1:0]    lives_n;
  logic [15:0]   score_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ball_lost, hold_done;
  logic [16:0]   pts;

  assign ball_lost = startOfFrame && (smileyTopLeftY > BOTTOM_S);
  assign hold_done = (cnt == CW'(HOLD_FRAMES));
  assign pts       = 17'(POINTS_PER_HIT * (int'(level) + 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
      level <= '0;
      lives <= INIT_LIVES;
      score <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      level <= level_n;
      lives <= lives_n;
      score <= score_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    lives_n = lives;
    score_n = score;
    cnt_n   = cnt;
    // Scoring rides alongside any PLAY exit taken in the same cycle.
    if (hit_p && state == PLAY) score_n = sat_add(score, pts);
    case (state)
      IDLE:   if (start_p) state_n = SERVE;
      SERVE:  state_n = PLAY;
      PLAY: begin
        if (levelCleared) begin
          if (level == LAST_LEVEL) state_n = WIN;
          else begin
            level_n = level + 4'd1;
            cnt_n   = '0;
            state_n = LEVEL_UP;
          end
        end else if (ball_lost) begin
          lives_n = lives - 2'd1;
          if (lives == 2'd1) state_n = GAME_OVER;
          else begin
            cnt_n   = '0;
            state_n = BALL_LOST;
          end
        end else if (pause_p) state_n = PAUSED;
      end
      PAUSED: if (pause_p) state_n = PLAY;
      BALL_LOST: begin
        if (startOfFrame && !hold_done) cnt_n = cnt + CW'(1);
`ifdef AUTO_SERVE_EN
        if (hold_done) state_n = SERVE;
`else
        if (hold_done && start_p) state_n = SERVE;
`endif
      end
      LEVEL_UP: begin
        if (startOfFrame && !hold_done) cnt_n = cnt + CW'(1);
        if (hold_done) state_n = SERVE;
      end
      GAME_OVER, WIN: begin
        if (start_p) begin
          score_n = '0;
          lives_n = INIT_LIVES;
          level_n = '0;
          state_n = SERVE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign pause       = (state != PLAY);
  assign reset_level = (state == SERVE);
  assign gameOver    = (state == GAME_OVER);
  assign win         = (state == WIN);
endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
Top-level game sequencer that drives the ball (smiley) controller's `pause`, `reset_level` and `level` inputs. It also owns lives, score and win/lose status.
- Watches the ball's vertical position to detect a lost ball.
- Counts obstacle hits for score.
- Sequences serve, play, pause, level-up and end-of-game via an FSM clocked at pixel-clock rate and paced by `startOfFrame`.

Parameters:
- INITIAL_LIVES, 3, lives loaded on reset and on new game (1..3).
- NUM_LEVELS, 4, number of levels; level runs 0..NUM_LEVELS-1 (≤16).
- BOTTOM_Y, 479, ball is lost when smileyTopLeftY > BOTTOM_Y.
- HOLD_FRAMES, 60, frames spent in BALL_LOST / LEVEL_UP before proceeding (≥1).
- POINTS_PER_HIT, 10, base score per obstacle hit; multiplied by (level+1).

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse per video frame
- keyStartIsPressed  in  1  debounced level, start/serve key
- keyPauseIsPressed  in  1  debounced level, pause toggle key
- smileyTopLeftY  in  11 signed  ball top-left Y, integer pixels
- collisionSmileyObstacle  in  1  level, ball overlapping obstacle
- levelCleared  in  1  level, all obstacles of current level destroyed
- pause  out  1  freeze ball motion
- reset_level  out  1  one-cycle pulse: re-init ball for current level
- level  out  4  current level, 0-based
- lives  out  2  remaining lives
- score  out  16  accumulated score, saturating
- gameOver  out  1  high in GAME_OVER
- win  out  1  high in WIN

Behaviour:
- Reset (async, resetN=0) forces:
  - state=IDLE, level=0, lives=INITIAL_LIVES, score=0, frame counter=0, edge-detect history=0.
  - Outputs: pause=1, reset_level=0, gameOver=0, win=0.
- Key and collision inputs are rising-edge detected against a 1-cycle registered history. Only edges act; held keys do not repeat.
- Outputs are Moore:
  - pause = (state != PLAY).
  - reset_level = (state == SERVE).
  - gameOver = (state == GAME_OVER); win = (state == WIN).
- States and transitions (one per clk unless noted):
  - IDLE: start edge -> SERVE.
  - SERVE: exactly one cycle, unconditional -> PLAY. The ball controller re-inits using the current `level`.
  - PLAY: priority levelCleared > ball-lost > pause edge.
    - levelCleared, level==NUM_LEVELS-1 -> WIN.
    - levelCleared, otherwise: level<=level+1, counter<=0 -> LEVEL_UP.
    - Ball-lost is evaluated only when startOfFrame=1 and smileyTopLeftY > BOTTOM_Y (signed compare; negative Y is never lost).
      - lives==1: lives<=0 -> GAME_OVER.
      - otherwise: lives<=lives-1, counter<=0 -> BALL_LOST.
    - Pause edge -> PAUSED.
  - PAUSED: pause edge -> PLAY, with no reset_level. Start edge is ignored.
  - BALL_LOST: counter increments on each startOfFrame. When counter reaches HOLD_FRAMES: set done flag, then wait for a start edge -> SERVE.
  - LEVEL_UP: same counting; at HOLD_FRAMES -> SERVE automatically (no key).
  - GAME_OVER / WIN: start edge -> new game: score<=0, lives<=INITIAL_LIVES, level<=0 -> SERVE.
- Score:
  - On a collision rising edge while state==PLAY, score <= min(score + POINTS_PER_HIT*(level+1), 16'hFFFF).
  - Compute in 17+ bits, then saturate.
  - A hit in the same cycle as a PLAY exit still scores.
  - No scoring in any other state.
- Simultaneous events:
  - levelCleared and ball-lost in the same cycle: level-up wins, lives unchanged.
  - Pause edge in the same cycle as either: ignored.
- Frame counter width is $clog2(HOLD_FRAMES+1). It saturates at HOLD_FRAMES.
- Mid-operation reset returns to IDLE immediately, including from SERVE. reset_level drops asynchronously with the state.

Optional Feature:
- AUTO_SERVE_EN defined: BALL_LOST proceeds to SERVE automatically when the counter reaches HOLD_FRAMES, and start edges are ignored there.
- Not defined: BALL_LOST requires a start edge after the hold has elapsed. Start edges before the hold elapses are ignored and are not queued.

Decomposition:
- Shared package `game_defines`: typedef enum game_state_t {IDLE, SERVE, PLAY, PAUSED, BALL_LOST, LEVEL_UP, GAME_OVER, WIN}, plus MAX_SCORE=16'hFFFF. Parameter defaults are mirrored as package constants for top-level use.
- One sub-module: `rise_edge_detector` (clk, resetN, in, pulse), instantiated three times (start, pause, collision).

Test Plan:
- Serve: reset, start edge -> SERVE 1 cycle with reset_level=1 and pause=1, then PLAY with pause=0. Holding start for 100 cycles produces one serve only.
- Ball lost: PLAY, lives=3, Y=480 at startOfFrame -> lives=2, BALL_LOST. After 60 frames plus a start edge (macro off) -> reset_level pulse. With AUTO_SERVE_EN, the pulse follows after frame 60 with no key.
- Scoring: level=2, collision held 50 cycles -> score +30 once. At score=65530, one hit -> score=65535.
- Level/win: levelCleared at level 0 -> LEVEL_UP, level=1, 60 frames, SERVE. levelCleared at level 3 -> win=1. Start edge -> level=0, score=0, lives=3, SERVE.
- Game over and priority: lives=1, Y=500 at startOfFrame together with levelCleared -> LEVEL_UP, lives stays 1. Next play, Y=500 -> gameOver=1, lives=0.
- Pause: pause edge in PLAY -> pause=1, no reset_level. Collision edges while paused leave score unchanged. Second pause edge -> PLAY. resetN low mid-PAUSED -> IDLE, all outputs at reset values.
